d16_fetch: RTL

- Instruction fetch stage of the d16 core. It sits directly upstream of d16_decode and drives its 32-bit instr word.
- Keeps the program counter and issues word reads to instruction memory, which may take a variable number of cycles to respond.
- Buffers returned words in a small FIFO and presents them over a valid/ready handshake.
- Accepts a one-cycle jump redirect from the execute stage, which flushes the buffered words and any word still in flight.

---
 rtl/d16_pkg.sv | 20 ++
 rtl/d16_ififo.sv | 82 ++++++++
 rtl/d16_fetch.sv | 124 ++++++++++++
 3 files changed

// File: rtl/d16_pkg.sv
// rtl/d16_pkg.sv - shared d16 fetch defaults and the fetch request state type
//
// Defaults for the fetch stage's word-address width, FIFO depth and reset PC,
// and the encoded state type of the memory request FSM.

package d16_pkg;

  localparam int          D16_AW          = 16;
  localparam int          D16_FETCH_DEPTH = 2;
  localparam logic [15:0] D16_RESET_PC    = 16'h0000;

  // ST_DISCARD is a request in flight whose data must be thrown away because
  // a redirect arrived after it was issued.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/d16_ififo.sv
// rtl/d16_ififo.sv - synchronous instruction FIFO of the d16 fetch stage
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   push, din    write din at the tail
//   pop          drop the head entry
//   flush        empty the FIFO; wins over push and pop
//   head         current head entry (registered storage, no bypass from din)
//   empty, full  occupancy flags
//   count        number of valid entries, 0..DEPTH

module d16_ififo #(
  parameter int  W     = 48,
  parameter int  DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO may still accept a word if the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = din;
        wr_d        = wr_q + PW'(1);
      end
      if (do_pop) begin
        rd_d = rd_q + PW'(1);
      end
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/d16_fetch.sv
// rtl/d16_fetch.sv - d16 instruction fetch stage: PC, memory requests, FIFO
//
// Ports:
//   sys_clk, sys_rst_n   clock and asynchronous active-low reset
//   en                   fetch enable; low stops new requests
//   im_adr, im_stb       registered word request, held until im_ack
//   im_ack, im_dat       memory response
//   instr, instr_pc      FIFO head word and its address
//   instr_valid          FIFO not empty
//   instr_ready          downstream accepts the head
//   jmp_en, jmp_addr     redirect pulse and target

module d16_fetch
  import d16_pkg::*;
#(
  parameter int            AW       = D16_AW,
  parameter int            DEPTH    = D16_FETCH_DEPTH,
  parameter logic [AW-1:0] RESET_PC = AW'(D16_RESET_PC)
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          en,
  output logic [AW-1:0] im_adr,
  output logic          im_stb,
  input  logic          im_ack,
  input  logic [31:0]   im_dat,
  output logic [31:0]   instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          jmp_en,
  input  logic [AW-1:0] jmp_addr
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e   state_q, state_d;
  logic [AW-1:0]  pc_q, pc_d;
  logic [AW-1:0]  adr_q, adr_d;

  logic           stb_ack;
  logic           push, pop, issue;
  logic [CW-1:0]  fifo_count, count_after;
  logic           fifo_empty, fifo_full;
  logic [AW+31:0] fifo_head;

  // An ack only means something while a request is actually on the bus.
  assign stb_ack = im_ack && (state_q != ST_IDLE);

  // A redirect flushes the FIFO, so the pop and any live push are moot then.
  assign pop  = !fifo_empty && instr_ready && !jmp_en;
  assign push = stb_ack && (state_q == ST_REQ) && !jmp_en && (!fifo_full || pop);

  // Occupancy once this cycle's push and pop land; a new request reserves the
  // slot its word will need, so the FIFO cannot overflow.
  assign count_after = fifo_count + CW'(push) - CW'(pop);

  assign issue = en && !jmp_en && (count_after < CW'(DEPTH)) &&
                 ((state_q == ST_IDLE) || ((state_q == ST_REQ) && stb_ack));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    adr_d   = adr_q;

    if (jmp_en) begin
      pc_d = jmp_addr;
    end else if (push) begin
      pc_d = pc_q + AW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (issue) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (stb_ack)     state_d = issue ? ST_REQ : ST_IDLE;
        else if (jmp_en) state_d = ST_DISCARD;
      end
      ST_DISCARD: begin
        if (stb_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Back-to-back requests target the already incremented PC.
    if (issue) adr_d = pc_d;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      adr_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      adr_q   <= adr_d;
    end
  end

  d16_ififo #(
    .W     (AW + 32),
    .DEPTH (DEPTH)
  ) u_ififo (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .push  (push),
    .pop   (pop),
    .flush (jmp_en),
    .din   ({pc_q, im_dat}),
    .head  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign im_stb      = (state_q != ST_IDLE);
  assign im_adr      = adr_q;
  assign instr       = fifo_head[31:0];
  assign instr_pc    = fifo_head[AW+31:32];
  assign instr_valid = !fifo_empty;

endmodule
